pattern_scan_ctrl: RTL and testbench

Controller that sequences the serial pattern-detection datapath. It accepts parallel words over a valid/ready handshake and serialises them MSB-first into a programmable overlapping pattern-match core, one bit per clock. It counts matches and raises a sticky threshold interrupt. It sits between the word-oriented stream source and the status/interrupt logic, and owns arming, abort and reconfiguration of the detector.

---
 rtl/pattern_scan_pkg.sv | 7 +
 rtl/pattern_scan_ctrl_if.sv | 8 +
 rtl/pattern_match_core.sv | 38 +++
 rtl/pattern_scan_ctrl.sv | 93 +++++++++
 tb/tb_pattern_scan_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: scan FSM state encoding and default widths shared by the pattern scan controller and its bench
package pattern_scan_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int PAT_W_DEF = 5;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_e;
endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: word stream handshake (in_valid/in_data from source, in_ready back), master = source, slave = controller
interface pattern_scan_ctrl_if #(parameter int DATA_W = 8);
  logic in_valid;
  logic [DATA_W-1:0] in_data;
  logic in_ready;
  modport master (output in_valid, in_data, input in_ready);
  modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/pattern_match_core.sv
// pattern_match_core: serial overlapping matcher; ports clk_i, rst_ni, clear_i, valid_i, bit_i, pattern_i (MSB vs oldest bit), registered match_o
module pattern_match_core #(
  parameter int PAT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             match_o
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] hist_q, hist_d, hist_s;
  logic [FW-1:0] fill_q, fill_d;
  logic match_q, match_d;
  always_comb begin
    hist_s = (hist_q << 1) | PAT_W'(bit_i);
    hist_d = valid_i ? hist_s : hist_q;
    fill_d = valid_i && fill_q != FW'(PAT_W) ? fill_q + 1'b1 : fill_q;
    match_d = valid_i && fill_q >= FW'(PAT_W - 1) && hist_s == pattern_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
      match_q <= 1'b0;
    end else if (clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      match_q <= match_d;
    end
  assign match_o = match_q;
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serialises in_if words MSB-first into the match core; ports clk_i/rst_ni, start_i/stop_i, cfg_pattern_i/cfg_thresh_i, in_if, irq_clr_i, match_o/match_cnt_o/irq_o/busy_o; PSC_AUTO_STOP_EN parks in IDLE after irq
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [CNT_W-1:0] cfg_thresh_i,
  input  logic             irq_clr_i,
  pattern_scan_ctrl_if.slave in_if,
  output logic             match_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             irq_o,
  output logic             busy_o
);
  localparam int IW = $clog2(DATA_W);
  state_e state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] thr_q, cnt_q, cnt_d;
  logic irq_q, irq_d, last, ready, hs, inc, set, halt;
`ifdef PSC_AUTO_STOP_EN
  logic halt_q;
  assign halt = halt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) halt_q <= 1'b0;
    else halt_q <= start_i ? 1'b0 : halt_q | set;
`else
  assign halt = 1'b0;
`endif
  always_comb begin
    last = idx_q == IW'(DATA_W - 1);
    ready = !halt && (state_q == ARMED || (state_q == SHIFT && last));
    hs = in_if.in_valid && ready;
    state_d = state_q;
    sh_d = sh_q;
    idx_d = idx_q;
    if (start_i) state_d = ARMED;
    else if (stop_i) state_d = IDLE;
    else if (hs) begin
      state_d = SHIFT;
      sh_d = in_if.in_data;
      idx_d = '0;
    end else if (state_q == SHIFT && !last) begin
      sh_d = sh_q << 1;
      idx_d = idx_q + 1'b1;
    end else if (state_q != IDLE) state_d = halt ? IDLE : ARMED;
    inc = match_o && cnt_q != '1;
    set = inc && cnt_q + 1'b1 == thr_q && thr_q != '0;
    cnt_d = start_i ? '0 : cnt_q + CNT_W'(inc);
    irq_d = !start_i && (set || (irq_q && !irq_clr_i));
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      sh_q <= '0;
      idx_q <= '0;
      pat_q <= '0;
      thr_q <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
      if (start_i) begin
        pat_q <= cfg_pattern_i;
        thr_q <= cfg_thresh_i;
      end
    end
  pattern_match_core #(.PAT_W(PAT_W)) u_core (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (start_i),
    .valid_i   (state_q == SHIFT),
    .bit_i     (sh_q[DATA_W-1]),
    .pattern_i (pat_q),
    .match_o   (match_o)
  );
  assign in_if.in_ready = ready;
  assign match_cnt_o = cnt_q;
  assign irq_o = irq_q;
  assign busy_o = state_q == SHIFT;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: randomized and directed scoreboard bench for pattern_scan_ctrl against a bit-queue reference model
module tb_pattern_scan_ctrl;
  localparam int DW = 8;
  localparam int PW = 5;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clr = 1'b0;
  logic [PW-1:0] pat = 5'b01101;
  logic [CW-1:0] thr = '0;
  logic match, irq, busy;
  logic [CW-1:0] cnt;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];
  logic [PW-1:0] m_pat;
  logic [CW-1:0] m_thr, m_cnt;
  bit m_irq, m_on, m_pend, m_halt;
  bit m_bits[$];
  bit m_hist[$];
  pattern_scan_ctrl_if #(.DATA_W(DW)) bus();
  pattern_scan_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .stop_i        (stop),
    .cfg_pattern_i (pat),
    .cfg_thresh_i  (thr),
    .irq_clr_i     (clr),
    .in_if         (bus),
    .match_o       (match),
    .match_cnt_o   (cnt),
    .irq_o         (irq),
    .busy_o        (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (match) begin
      if (exp_q.size() == 0) chk("spurious_match", match, 0);
      else chk("match_cycle", cyc, exp_q.pop_front());
    end else if (exp_q.size() > 0 && exp_q[0] <= cyc) chk("missed_match", cyc, exp_q.pop_front());
  end
  function automatic bit hit();
    if (m_hist.size() < PW) return 0;
    for (int i = 0; i < PW; i++) if (m_hist[i] != m_pat[PW-1-i]) return 0;
    return 1;
  endfunction
  task automatic step(input bit st, input bit sp, input bit v, input logic [DW-1:0] d, output bit acc);
    bit rdy, pend_n;
    start = st;
    stop = sp;
    bus.in_valid = v;
    bus.in_data = d;
    rdy = m_on && m_bits.size() <= 1 && !m_halt;
    chk("in_ready", bus.in_ready, rdy);
    chk("busy", busy, m_bits.size() > 0);
    chk("match_cnt", cnt, m_cnt);
    chk("irq", irq, m_irq);
    acc = rdy && v && !st && !sp;
    pend_n = 0;
    if (st) begin
      m_pat = pat;
      m_thr = thr;
      m_cnt = '0;
      m_irq = 0;
      m_halt = 0;
      m_on = 1;
      m_hist.delete();
      m_bits.delete();
    end else begin
      bit set = 0;
      if (m_pend && m_cnt != '1) begin
        m_cnt++;
        set = m_cnt == m_thr && m_thr != 0;
      end
      m_irq = set || (m_irq && !clr);
`ifdef PSC_AUTO_STOP_EN
      if (set) m_halt = 1;
`endif
      if (m_bits.size() > 0) begin
        m_hist.push_back(m_bits.pop_front());
        if (m_hist.size() > PW) void'(m_hist.pop_front());
        if (hit()) begin
          pend_n = 1;
          exp_q.push_back(cyc + 1);
        end
      end
      if (sp) begin
        m_on = 0;
        m_bits.delete();
      end else if (acc) for (int i = DW - 1; i >= 0; i--) m_bits.push_back(d[i]);
    end
    m_pend = pend_n;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, acc);
  endtask
  task automatic do_start(input logic [PW-1:0] p, input logic [CW-1:0] t);
    bit acc;
    pat = p;
    thr = t;
    step(1, 0, 0, '0, acc);
  endtask
  task automatic send(input logic [DW-1:0] d);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 40) begin
      step(0, 0, 1, d, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: word %0h not accepted within %0d cycles", d, n);
    end
  endtask
  task automatic do_reset();
    start = 0;
    stop = 0;
    bus.in_valid = 0;
    #2 rst_n = 1'b0;
    m_on = 0;
    m_pend = 0;
    m_halt = 0;
    m_cnt = '0;
    m_irq = 0;
    m_bits.delete();
    m_hist.delete();
    exp_q.delete();
    #1;
    chk("rst_match", match, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_irq", irq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bit acc;
    bus.in_valid = 0;
    bus.in_data = '0;
    do_reset();
    idle(3);
    do_start(5'b01101, 0);
    send(8'h68);
    idle(12);
    chk("t68_cnt", cnt, 1);
    do_start(5'b01101, 0);
    send(8'h6D);
    idle(12);
    chk("t6d_cnt", cnt, 2);
    do_start(5'b01101, 0);
    send(8'h03);
    send(8'h5F);
    idle(12);
    chk("boundary_cnt", cnt, 1);
    do_start(5'b01101, 2);
    send(8'h6D);
    idle(12);
    chk("thresh_irq", irq, 1);
    do_start(5'b01101, 3);
    send(8'h6D);
    clr = 1;
    send(8'h6D);
    idle(12);
    clr = 0;
    idle(4);
    do_start(5'b01101, 0);
    send(8'h68);
    idle(3);
    do_reset();
    idle(12);
    chk("post_reset_cnt", cnt, 0);
    do_start(5'b01101, 0);
    send(8'h03);
    idle(1);
    step(0, 1, 0, '0, acc);
    do_start(5'b01101, 0);
    send(8'h5F);
    idle(12);
    chk("stop_restart_cnt", cnt, 0);
    do_start(5'b01101, 1);
    for (int n = 0; n < 4000; n++) begin
      bit st, sp;
      st = $urandom_range(0, 79) == 0;
      sp = $urandom_range(0, 149) == 0;
      if (st) begin
        pat = PW'($urandom);
        thr = CW'($urandom_range(0, 5));
      end
      clr = $urandom_range(0, 15) == 0;
      step(st, sp, $urandom_range(0, 3) != 0, DW'($urandom), acc);
    end
    clr = 0;
    idle(20);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
